// File: rtl/rr_arbiter_dec8_pkg.sv
// Shared types and helpers for the eight-way round-robin arbiter.
// Holds the FSM state encoding, requester sizing and the rotating-priority scan.
package rr_arbiter_dec8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } scan_t;

  // First set request at or after ptr, wrapping 7 -> 0. Scanning from the far
  // end lets the nearest candidate overwrite earlier hits.
  function automatic scan_t rr_scan(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr);
    scan_t            res;
    logic [IDX_W-1:0] cand;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_dec8_dec.sv
// Combinational 3:8 one-hot decoder; the arbiter registers its output.
module onehot_dec3to8
  import rr_arbiter_dec8_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
    assign onehot[gi] = (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/rr_arbiter_dec8.sv
// Eight-requester round-robin arbiter with hold-limit timeout.
// Grants are registered and always separated by at least one dead cycle.
module rr_arbiter_dec8
  import rr_arbiter_dec8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  state_t                state_reg;
  logic [IDX_W-1:0]      ptr_reg;
  logic [CNT_W-1:0]      hold_cnt_reg;
  logic [NUM_REQ-1:0]    gnt_reg;
  logic [IDX_W-1:0]      gnt_idx_reg;
  logic                  gnt_valid_reg;
  logic                  timeout_reg;

  scan_t                 scan;
  logic [NUM_REQ-1:0]    dec_onehot;
  logic                  req_held;
  logic                  hold_hit;
  logic                  hold_sat;

  onehot_dec3to8 u_dec (
    .idx    (gnt_idx_reg),
    .onehot (dec_onehot)
  );

  always_comb begin
    scan     = rr_scan(req, ptr_reg);
    req_held = req[gnt_idx_reg];
    hold_hit = (MAX_HOLD != 0) && (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
    hold_sat = &hold_cnt_reg;
  end

  // gnt only rises once the holder is confirmed still requesting, which is
  // what gives the two-edge request-to-grant latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
      gnt_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          gnt_reg       <= '0;
          gnt_valid_reg <= 1'b0;
          if (en && scan.found) begin
            gnt_idx_reg  <= scan.idx;
            hold_cnt_reg <= '0;
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          if (!hold_sat) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
          if (!req_held) begin
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            state_reg     <= RELEASE;
          end else if (hold_hit) begin
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            timeout_reg   <= 1'b1;
            state_reg     <= RELEASE;
          end else begin
            gnt_reg       <= dec_onehot;
            gnt_valid_reg <= 1'b1;
          end
        end
        RELEASE: begin
          gnt_reg       <= '0;
          gnt_valid_reg <= 1'b0;
          ptr_reg       <= gnt_idx_reg + 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = gnt_idx_reg;
  assign gnt_valid = gnt_valid_reg;
  assign timeout   = timeout_reg;

endmodule
